irq_bridge: RTL

//   System bridge between the CPU data port and NDEV memory-mapped peripherals (timers first).

---
 rtl/irq_bridge_if.sv | 47 ++++
 rtl/irq_bridge.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/irq_bridge_if.sv
// irq_bridge_if: bundle of every non-clock signal between the CPU data port,
// the NDEV memory-mapped peripherals and the interrupt bridge.
//
// Signals (direction as seen by the bridge, modport slave):
//   PrAddr   in   32       CPU byte address (bits 1:0 ignored)
//   PrWEn    in   1        CPU write strobe, one cycle per write
//   PrWData  in   32       CPU write data
//   PrRData  out  32       read data, combinational from PrAddr
//   DevAddr  out  2        PrAddr[3:2] fanned out to every device
//   DevWData out  32       PrWData fanned out to every device
//   DevWEn   out  NDEV     one-hot per-device write enable
//   DevRData in   32*NDEV  device i read data at [32*i+31:32*i]
//   DevIRQ   in   NDEV     device interrupt levels, synchronous to the clock
//   IntReq   out  1        registered CPU interrupt request
//   IntAck   in   1        one-cycle acknowledge of the current interrupt ID
//
// Handshake semantics: there is no valid/ready pair on this bus. A CPU write
// is a single-cycle PrWEn strobe that every target consumes on the same
// posedge; reads are combinational and complete in the cycle PrAddr is held.
// IntAck is a one-cycle pulse that retires the source currently shown in ID.
interface irq_bridge_if #(
  parameter int NDEV = 4
);
  logic [31:0]          PrAddr;
  logic                 PrWEn;
  logic [31:0]          PrWData;
  logic [31:0]          PrRData;
  logic [1:0]           DevAddr;
  logic [31:0]          DevWData;
  logic [NDEV-1:0]      DevWEn;
  logic [32*NDEV-1:0]   DevRData;
  logic [NDEV-1:0]      DevIRQ;
  logic                 IntReq;
  logic                 IntAck;

  // Bridge side.
  modport slave (
    input  PrAddr, PrWEn, PrWData, DevRData, DevIRQ, IntAck,
    output PrRData, DevAddr, DevWData, DevWEn, IntReq
  );

  // CPU/peripheral side (used by the environment driving the bridge).
  modport master (
    output PrAddr, PrWEn, PrWData, DevRData, DevIRQ, IntAck,
    input  PrRData, DevAddr, DevWData, DevWEn, IntReq
  );
endinterface

// File: rtl/irq_bridge.sv
// irq_bridge: address decoder, read mux and interrupt controller sitting
// between the CPU data port and NDEV memory-mapped peripherals.
//
// Ports:
//   Clk  in   clock, all state updates on posedge
//   Rst  in   asynchronous, active-high reset
//   bus  irq_bridge_if.slave (CPU port, device fan-out, IRQ lines, IntReq/IntAck)
//
// Address map (16-byte blocks from BASE):
//   BASE + 16*i     device i, i < NDEV (DevAddr = PrAddr[3:2])
//   BASE + 16*NDEV  controller: +0 MASK (RW), +4 PEND (R, W1C),
//                               +8 ID (RO), +C RAW (RO)
// Anything else reads 0 and writes nowhere.
//
// Handshake semantics: PrWEn is a one-cycle strobe consumed on the same
// posedge by whichever target decodes the address; reads are combinational.
// IntAck is a one-cycle pulse that clears the pending bit shown in ID.
module irq_bridge #(
  parameter int          NDEV = 4,
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic         Clk,
  input  logic         Rst,
  irq_bridge_if.slave  bus
);

  localparam logic [27:0] BASE_BLK = BASE[31:4];

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_ID   = 2'd2;
  localparam logic [1:0] REG_RAW  = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NDEV-1:0] r_mask;
  logic [NDEV-1:0] r_pend;
  logic [NDEV-1:0] r_irq_q;
  logic            r_int_req;

  // ---------------------------------------------------------------------------
  // Decode: w_hit[i] for devices, w_hit[NDEV] for the controller block
  // ---------------------------------------------------------------------------
  logic [NDEV:0]   w_hit;
  logic [1:0]      w_reg_sel;
  logic            w_ctrl_we;
  logic            w_unused_addr;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i <= NDEV; i++) begin
      w_hit[i] = (bus.PrAddr[31:4] == BASE_BLK + 28'(i));
    end
  end

  assign w_reg_sel     = bus.PrAddr[3:2];
  assign w_ctrl_we     = w_hit[NDEV] & bus.PrWEn;
  // Byte offset within a word is not decoded.
  assign w_unused_addr = ^bus.PrAddr[1:0];

  assign bus.DevAddr  = bus.PrAddr[3:2];
  assign bus.DevWData = bus.PrWData;
  assign bus.DevWEn   = w_hit[NDEV-1:0] & {NDEV{bus.PrWEn}};

  // ---------------------------------------------------------------------------
  // Interrupt priority: lowest set index of PEND & MASK wins
  // ---------------------------------------------------------------------------
  logic [NDEV-1:0] w_active;
  logic            w_id_valid;
  logic [2:0]      w_id_idx;

  assign w_active = r_pend & r_mask;

  always_comb begin
    w_id_valid = |w_active;
    w_id_idx   = 3'd0;
    // Walk from the top down so the lowest index is the last one written.
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_id_idx = 3'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending update
  // ---------------------------------------------------------------------------
  logic [NDEV-1:0] w_rise;
  logic [NDEV-1:0] w_w1c;
  logic [NDEV-1:0] w_ack_clr;
  logic [NDEV-1:0] w_pend_next;
  logic            w_mask_we;

  assign w_rise    = bus.DevIRQ & ~r_irq_q;
  assign w_mask_we = w_ctrl_we && (w_reg_sel == REG_MASK);
  assign w_w1c     = (w_ctrl_we && (w_reg_sel == REG_PEND)) ? bus.PrWData[NDEV-1:0]
                                                            : '0;

  // An acknowledge with no valid ID clears nothing.
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NDEV; i++) begin
      w_ack_clr[i] = bus.IntAck && w_id_valid && (w_id_idx == 3'(i));
    end
  end

  // The rise term is OR-ed in after clearing, so a same-cycle set wins.
  assign w_pend_next = (r_pend & ~(w_w1c | w_ack_clr)) | w_rise;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_mask    <= '0;
      r_pend    <= '0;
      r_irq_q   <= '0;
      r_int_req <= 1'b0;
    end else begin
      r_irq_q   <= bus.DevIRQ;
      r_pend    <= w_pend_next;
      if (w_mask_we) begin
        r_mask <= bus.PrWData[NDEV-1:0];
      end
      // Registered from the current PEND/MASK: one edge after either changes.
      r_int_req <= |(r_pend & r_mask);
    end
  end

  assign bus.IntReq = r_int_req;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = 32'd0;
    for (int i = 0; i < NDEV; i++) begin
      if (w_hit[i]) begin
        w_rdata = bus.DevRData[32*i +: 32];
      end
    end
    if (w_hit[NDEV]) begin
      case (w_reg_sel)
        REG_MASK: w_rdata = 32'(r_mask);
        REG_PEND: w_rdata = 32'(r_pend);
        REG_ID:   w_rdata = {w_id_valid, 28'd0, w_id_idx};
        REG_RAW:  w_rdata = 32'(bus.DevIRQ);
        default:  w_rdata = 32'd0;
      endcase
    end
  end

  assign bus.PrRData = w_rdata;

endmodule
